alu_sequencer: RTL and testbench

ALU_SEQUENCER -- requirements
Module: alu_sequencer

---
 rtl/alu_sequencer_pkg.sv | 21 ++
 rtl/alu_sequencer_regfile.sv | 31 +++
 rtl/alu_sequencer.sv | 116 +++++++++++
 tb/tb_alu_sequencer.sv | 297 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/alu_sequencer_pkg.sv
// rtl/alu_sequencer_pkg.sv - shared opcodes, func7 codes and sequencer state type
package alu_sequencer_pkg;

  localparam logic [6:0] OP_REG  = 7'b0110011;
  localparam logic [6:0] OP_IMM  = 7'b0010011;
  localparam logic [6:0] F7_BASE = 7'h00;
  localparam logic [6:0] F7_ALT  = 7'h20;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    WB   = 2'd2,
    ILL  = 2'd3
  } state_t;

  // func3 values whose I-type form carries a shamt plus func7 instead of a 12-bit immediate
  function automatic logic is_shift_f3(input logic [2:0] f3);
    return (f3 == 3'b001) || (f3 == 3'b101);
  endfunction

endpackage

// File: rtl/alu_sequencer_regfile.sv
// rtl/alu_sequencer_regfile.sv - 32x32 register file, two async read ports, one sync write, x0 tied to zero
module alu_sequencer_regfile #(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic [4:0]      raddr1,
  input  logic [4:0]      raddr2,
  output logic [XLEN-1:0] rdata1,
  output logic [XLEN-1:0] rdata2,
  input  logic            we,
  input  logic [4:0]      waddr,
  input  logic [XLEN-1:0] wdata
);

  logic [XLEN-1:0] regs [1:31];

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 1; i < 32; i++) begin
        regs[i] <= '0;
      end
    end else if (we && (waddr != 5'd0)) begin
      regs[waddr] <= wdata;
    end
  end

  assign rdata1 = (raddr1 == 5'd0) ? '0 : regs[raddr1];
  assign rdata2 = (raddr2 == 5'd0) ? '0 : regs[raddr2];

endmodule

// File: rtl/alu_sequencer.sv
// rtl/alu_sequencer.sv - serial RV32I OP/OP-IMM sequencer driving an external combinational ALU
module alu_sequencer
  import alu_sequencer_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            instr_valid,
  input  logic [31:0]     instr,
  output logic            instr_ready,
  output logic [XLEN-1:0] alu_op1,
  output logic [XLEN-1:0] alu_op2,
  output logic [2:0]      alu_func3,
  output logic [6:0]      alu_func7,
  input  logic [XLEN-1:0] alu_out,
  output logic            wb_valid,
  output logic [4:0]      wb_rd,
  output logic [XLEN-1:0] wb_data,
  output logic            illegal,
  output logic            busy
);

  state_t state, state_nx;

  logic [6:0]      opcode;
  logic [2:0]      f3;
  logic [6:0]      f7;
  logic [XLEN-1:0] rs1_data;
  logic [XLEN-1:0] rs2_data;
  logic            dec_legal;
  logic [XLEN-1:0] dec_op2;
  logic [6:0]      dec_func7;
  logic            accept;

  assign opcode = instr[6:0];
  assign f3     = instr[14:12];
  assign f7     = instr[31:25];

  alu_sequencer_regfile #(.XLEN(XLEN)) u_regfile (
    .clk    (clk),
    .rst_n  (rst_n),
    .raddr1 (instr[19:15]),
    .raddr2 (instr[24:20]),
    .rdata1 (rs1_data),
    .rdata2 (rs2_data),
    .we     (state == WB),
    .waddr  (wb_rd),
    .wdata  (wb_data)
  );

  always_comb begin
    dec_legal = 1'b0;
    dec_op2   = rs2_data;
    dec_func7 = f7;
    case (opcode)
      OP_REG: dec_legal = (f7 == F7_BASE) ||
                          ((f7 == F7_ALT) && ((f3 == 3'b000) || (f3 == 3'b101)));
      OP_IMM: begin
        if (is_shift_f3(f3)) begin
          dec_op2   = {{(XLEN-5){1'b0}}, instr[24:20]};
          dec_legal = (f7 == F7_BASE) || ((f7 == F7_ALT) && (f3 == 3'b101));
        end else begin
          // upper immediate bits are not an ALU modifier here, so force the base func7
          dec_op2   = {{(XLEN-12){instr[31]}}, instr[31:20]};
          dec_func7 = F7_BASE;
          dec_legal = 1'b1;
        end
      end
      default: dec_legal = 1'b0;
    endcase
  end

  assign accept = (state == IDLE) && instr_valid;

  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    if (instr_valid) state_nx = dec_legal ? EXEC : ILL;
      EXEC:    state_nx = WB;
      WB:      state_nx = IDLE;
      ILL:     state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state     <= IDLE;
      alu_op1   <= '0;
      alu_op2   <= '0;
      alu_func3 <= '0;
      alu_func7 <= '0;
      wb_rd     <= '0;
      wb_data   <= '0;
    end else begin
      state <= state_nx;
      if (accept && dec_legal) begin
        alu_op1   <= rs1_data;
        alu_op2   <= dec_op2;
        alu_func3 <= f3;
        alu_func7 <= dec_func7;
        wb_rd     <= instr[11:7];
      end
      if (state == EXEC) begin
        wb_data <= alu_out;
      end
    end
  end

  assign instr_ready = (state == IDLE);
  assign busy        = (state != IDLE);
  assign wb_valid    = (state == WB);
  assign illegal     = (state == ILL);

endmodule

// File: tb/tb_alu_sequencer.sv
// tb/tb_alu_sequencer.sv - self-checking bench for alu_sequencer
module tb_alu_sequencer;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        instr_valid;
  logic [31:0] instr;
  logic        instr_ready;
  logic [31:0] alu_op1, alu_op2, alu_out;
  logic [2:0]  alu_func3;
  logic [6:0]  alu_func7;
  logic        wb_valid;
  logic [4:0]  wb_rd;
  logic [31:0] wb_data;
  logic        illegal;
  logic        busy;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  alu_sequencer #(.XLEN(32)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .instr_valid (instr_valid),
    .instr       (instr),
    .instr_ready (instr_ready),
    .alu_op1     (alu_op1),
    .alu_op2     (alu_op2),
    .alu_func3   (alu_func3),
    .alu_func7   (alu_func7),
    .alu_out     (alu_out),
    .wb_valid    (wb_valid),
    .wb_rd       (wb_rd),
    .wb_data     (wb_data),
    .illegal     (illegal),
    .busy        (busy)
  );

  function automatic logic [31:0] tb_alu(input logic [31:0] a, input logic [31:0] b,
                                         input logic [2:0] f3, input logic [6:0] f7);
    logic signed [31:0] sa;
    sa = a;
    case (f3)
      3'd0:    return (f7 == 7'h20) ? a - b : a + b;
      3'd1:    return a << b[4:0];
      3'd2:    return {31'b0, $signed(a) < $signed(b)};
      3'd3:    return {31'b0, a < b};
      3'd4:    return a ^ b;
      3'd5:    return (f7 == 7'h20) ? 32'(sa >>> b[4:0]) : a >> b[4:0];
      3'd6:    return a | b;
      default: return a & b;
    endcase
  endfunction

  assign alu_out = tb_alu(alu_op1, alu_op2, alu_func3, alu_func7);

  // Architectural model: register array plus RV32I semantics computed from the instruction word
  logic [31:0] mregs [32];

  typedef struct {
    logic        legal;
    logic [4:0]  rd;
    logic [31:0] val;
    logic [31:0] op2;
    logic [6:0]  f7;
  } res_t;

  function automatic res_t ref_exec(input logic [31:0] ins);
    res_t r;
    logic [31:0] a, b, imm;
    logic [2:0]  f3;
    logic [6:0]  f7;
    logic [4:0]  sh;
    a   = (ins[19:15] == 0) ? 32'd0 : mregs[ins[19:15]];
    b   = (ins[24:20] == 0) ? 32'd0 : mregs[ins[24:20]];
    imm = {{20{ins[31]}}, ins[31:20]};
    f3  = ins[14:12];
    f7  = ins[31:25];
    sh  = ins[24:20];
    r.legal = 1'b0; r.rd = ins[11:7]; r.val = 32'd0; r.op2 = 32'd0; r.f7 = 7'd0;
    if (ins[6:0] == 7'b0110011) begin
      r.legal = (f7 == 7'h00) || (f7 == 7'h20 && (f3 == 3'd0 || f3 == 3'd5));
      r.op2 = b; r.f7 = f7;
      case (f3)
        3'd0: r.val = (f7 == 7'h20) ? a - b : a + b;
        3'd1: r.val = a << b[4:0];
        3'd2: r.val = ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
        3'd3: r.val = (a < b) ? 32'd1 : 32'd0;
        3'd4: r.val = a ^ b;
        3'd5: r.val = (f7 == 7'h20) ? 32'($signed(a) >>> b[4:0]) : a >> b[4:0];
        3'd6: r.val = a | b;
        default: r.val = a & b;
      endcase
    end else if (ins[6:0] == 7'b0010011) begin
      if (f3 == 3'd1 || f3 == 3'd5) begin
        r.legal = (f7 == 7'h00) || (f7 == 7'h20 && f3 == 3'd5);
        r.op2 = {27'b0, sh}; r.f7 = f7;
        if (f3 == 3'd1) r.val = a << sh;
        else r.val = (f7 == 7'h20) ? 32'($signed(a) >>> sh) : a >> sh;
      end else begin
        r.legal = 1'b1; r.op2 = imm; r.f7 = 7'h00;
        case (f3)
          3'd0: r.val = a + imm;
          3'd2: r.val = ($signed(a) < $signed(imm)) ? 32'd1 : 32'd0;
          3'd3: r.val = (a < imm) ? 32'd1 : 32'd0;
          3'd4: r.val = a ^ imm;
          3'd6: r.val = a | imm;
          default: r.val = a & imm;
        endcase
      end
    end
    return r;
  endfunction

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, got, exp);
    end
  endtask

  // Offers one instruction at a falling edge and samples cycles N+1, N+2 and N+3
  task automatic issue(input logic [31:0] ins, output logic ill1, output logic wb1,
                       output logic wb2, output logic [4:0] rd2, output logic [31:0] d2,
                       output logic [31:0] op2_1, output logic [6:0] f7_1,
                       output logic stable, output logic rdy3);
    int k;
    logic [31:0] s_op1;
    logic [2:0]  s_f3;
    k = 0;
    while (!instr_ready && k < 20) begin
      @(negedge clk);
      k++;
    end
    if (!instr_ready) check("ready_wait", {31'b0, instr_ready}, 32'd1);
    instr = ins;
    instr_valid = 1'b1;
    @(negedge clk);
    instr_valid = 1'b0;
    ill1 = illegal; wb1 = wb_valid; op2_1 = alu_op2; f7_1 = alu_func7;
    s_op1 = alu_op1; s_f3 = alu_func3;
    @(negedge clk);
    wb2 = wb_valid; rd2 = wb_rd; d2 = wb_data;
    stable = (alu_op1 == s_op1) && (alu_op2 == op2_1) && (alu_func3 == s_f3) && (alu_func7 == f7_1);
    @(negedge clk);
    rdy3 = instr_ready;
  endtask

  task automatic run_model(input logic [31:0] ins, input string tag);
    res_t r;
    logic ill1, wb1, wb2, stable, rdy3;
    logic [4:0] rd2;
    logic [31:0] d2, op2_1;
    logic [6:0] f7_1;
    r = ref_exec(ins);
    issue(ins, ill1, wb1, wb2, rd2, d2, op2_1, f7_1, stable, rdy3);
    check({tag, "_illegal"}, {31'b0, ill1}, {31'b0, !r.legal});
    check({tag, "_wb_valid"}, {31'b0, wb2}, {31'b0, r.legal});
    check({tag, "_ready_n3"}, {31'b0, rdy3}, 32'd1);
    if (r.legal) begin
      check({tag, "_wb_rd"}, {27'b0, rd2}, {27'b0, r.rd});
      check({tag, "_wb_data"}, d2, r.val);
      check({tag, "_alu_op2"}, op2_1, r.op2);
      check({tag, "_alu_func7"}, {25'b0, f7_1}, {25'b0, r.f7});
      check({tag, "_alu_stable"}, {31'b0, stable}, 32'd1);
      if (r.rd != 0) mregs[r.rd] = r.val;
    end
  endtask

  typedef struct {
    logic [31:0] ins;
    logic        legal;
    logic [4:0]  rd;
    logic [31:0] data;
    logic [6:0]  f7;
    logic [31:0] op2;
  } vec_t;

  vec_t tbl [10];

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic ill1, wb1, wb2, stable, rdy3;
    logic [4:0] rd2;
    logic [31:0] d2, op2_1, ins;
    logic [6:0] f7_1;
    res_t r;

    tbl[0] = '{32'h00500093, 1'b1, 5'd1, 32'h00000005, 7'h00, 32'h00000005};
    tbl[1] = '{32'h00700113, 1'b1, 5'd2, 32'h00000007, 7'h00, 32'h00000007};
    tbl[2] = '{32'h402081B3, 1'b1, 5'd3, 32'hFFFFFFFE, 7'h20, 32'h00000007};
    tbl[3] = '{32'h4011D213, 1'b1, 5'd4, 32'hFFFFFFFF, 7'h20, 32'h00000001};
    tbl[4] = '{32'hC0000293, 1'b1, 5'd5, 32'hFFFFFC00, 7'h00, 32'hFFFFFC00};
    tbl[5] = '{32'h0000007F, 1'b0, 5'd0, 32'h0,        7'h00, 32'h0};
    tbl[6] = '{32'h02208233, 1'b0, 5'd0, 32'h0,        7'h00, 32'h0};
    tbl[7] = '{32'h40109093, 1'b0, 5'd0, 32'h0,        7'h00, 32'h0};
    tbl[8] = '{32'h00900013, 1'b1, 5'd0, 32'h00000009, 7'h00, 32'h00000009};
    tbl[9] = '{32'h00000333, 1'b1, 5'd6, 32'h00000000, 7'h00, 32'h00000000};

    for (int i = 0; i < 32; i++) mregs[i] = 32'd0;
    rst_n = 1'b0; instr_valid = 1'b0; instr = 32'd0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check("rst_ready", {31'b0, instr_ready}, 32'd1);
    check("rst_busy", {31'b0, busy}, 32'd0);
    check("rst_wb_valid", {31'b0, wb_valid}, 32'd0);
    check("rst_illegal", {31'b0, illegal}, 32'd0);
    check("rst_alu_op1", alu_op1, 32'd0);
    check("rst_alu_op2", alu_op2, 32'd0);
    check("rst_func", {22'b0, alu_func3, alu_func7}, 32'd0);
    check("rst_wb_rd", {27'b0, wb_rd}, 32'd0);
    check("rst_wb_data", wb_data, 32'd0);

    for (int i = 0; i < 10; i++) begin
      issue(tbl[i].ins, ill1, wb1, wb2, rd2, d2, op2_1, f7_1, stable, rdy3);
      check($sformatf("vec%0d_illegal", i), {31'b0, ill1}, {31'b0, !tbl[i].legal});
      check($sformatf("vec%0d_wb_n1", i), {31'b0, wb1}, 32'd0);
      check($sformatf("vec%0d_wb_valid", i), {31'b0, wb2}, {31'b0, tbl[i].legal});
      check($sformatf("vec%0d_ready_n3", i), {31'b0, rdy3}, 32'd1);
      if (tbl[i].legal) begin
        check($sformatf("vec%0d_wb_rd", i), {27'b0, rd2}, {27'b0, tbl[i].rd});
        check($sformatf("vec%0d_wb_data", i), d2, tbl[i].data);
        check($sformatf("vec%0d_alu_func7", i), {25'b0, f7_1}, {25'b0, tbl[i].f7});
        check($sformatf("vec%0d_alu_op2", i), op2_1, tbl[i].op2);
        check($sformatf("vec%0d_stable", i), {31'b0, stable}, 32'd1);
      end
      r = ref_exec(tbl[i].ins);
      if (r.legal && r.rd != 0) mregs[r.rd] = r.val;
    end

    // instr_valid held high while busy must not sneak in a second instruction
    instr = 32'h00300393; instr_valid = 1'b1;
    @(negedge clk);
    instr = 32'h00400413;
    check("busy_n1", {31'b0, busy}, 32'd1);
    check("busy_ready_n1", {31'b0, instr_ready}, 32'd0);
    @(negedge clk);
    check("busy_wb_valid", {31'b0, wb_valid}, 32'd1);
    check("busy_wb_rd", {27'b0, wb_rd}, 32'd7);
    check("busy_wb_data", wb_data, 32'd3);
    instr_valid = 1'b0;
    @(negedge clk);
    check("busy_ready_n3", {31'b0, instr_ready}, 32'd1);
    mregs[7] = 32'd3;
    run_model(32'h000404B3, "x8_untouched");

    for (int n = 0; n < 200; n++) begin
      int sel, f7sel;
      logic [4:0] rd, rs1, rs2;
      logic [2:0] f3;
      logic [6:0] f7;
      sel = $urandom_range(0, 9);
      rd = 5'($urandom_range(0, 7)); rs1 = 5'($urandom_range(0, 7)); rs2 = 5'($urandom_range(0, 7));
      f3 = 3'($urandom_range(0, 7));
      f7sel = $urandom_range(0, 3);
      f7 = (f7sel < 2) ? 7'h00 : (f7sel == 2) ? 7'h20 : 7'($urandom);
      if (sel < 4) ins = {f7, rs2, rs1, f3, rd, 7'b0110011};
      else if (sel < 8 && (f3 == 3'd1 || f3 == 3'd5)) ins = {f7, 5'($urandom), rs1, f3, rd, 7'b0010011};
      else if (sel < 8) ins = {12'($urandom), rs1, f3, rd, 7'b0010011};
      else ins = $urandom;
      run_model(ins, $sformatf("rnd%0d", n));
    end

    // reset while in EXEC aborts the instruction
    instr = 32'h00100513; instr_valid = 1'b1;
    @(negedge clk);
    instr_valid = 1'b0;
    check("abort_in_exec", {31'b0, busy}, 32'd1);
    rst_n = 1'b0;
    @(negedge clk);
    check("abort_wb_valid_rst", {31'b0, wb_valid}, 32'd0);
    rst_n = 1'b1;
    for (int i = 0; i < 32; i++) mregs[i] = 32'd0;
    @(negedge clk);
    check("abort_ready_after", {31'b0, instr_ready}, 32'd1);
    check("abort_wb_valid_after", {31'b0, wb_valid}, 32'd0);
    check("abort_illegal_after", {31'b0, illegal}, 32'd0);
    check("abort_wb_data", wb_data, 32'd0);
    @(negedge clk);
    check("abort_wb_valid_later", {31'b0, wb_valid}, 32'd0);
    run_model(32'h00008333, "add_x6_after_rst");
    check("add_x6_is_zero", mregs[6], 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
